// File: rtl/tlb_pkg.sv
// Shared TLB field widths and the packed entry layout used by the entry array,
// the search sub-module and CP0-side users.
package tlb_pkg;

    localparam int TLB_VPN2_W = 19;
    localparam int TLB_ASID_W = 8;
    localparam int TLB_PFN_W  = 20;
    localparam int TLB_C_W    = 3;

    typedef struct packed {
        logic [TLB_VPN2_W-1:0] vpn2;
        logic [TLB_ASID_W-1:0] asid;
        logic                  g;
        logic [TLB_PFN_W-1:0]  pfn0;
        logic [TLB_C_W-1:0]    c0;
        logic                  d0;
        logic                  v0;
        logic [TLB_PFN_W-1:0]  pfn1;
        logic [TLB_C_W-1:0]    c1;
        logic                  d1;
        logic                  v1;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_match.sv
// One TLB search port: compares a VPN2/ASID against every entry, lowest index
// wins on multiple hits, then picks the even or odd page fields.
module tlb_match
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDX_W  = $clog2(TLBNUM)
) (
    input  tlb_entry_t             entries [TLBNUM],
    input  logic [TLB_VPN2_W-1:0]  vpn2,
    input  logic                   odd_page,
    input  logic [TLB_ASID_W-1:0]  asid,
    output logic                   found,
    output logic [IDX_W-1:0]       index,
    output logic [TLB_PFN_W-1:0]   pfn,
    output logic [TLB_C_W-1:0]     c,
    output logic                   d,
    output logic                   v
);

    tlb_entry_t sel;

    // Walk from the top down so the lowest matching index is the last one written.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        found = 1'b0;
        index = '0;
        sel   = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (entries[i].vpn2 == vpn2 && (entries[i].g || entries[i].asid == asid)) begin
                found = 1'b1;
                index = IDX_W'(i);
                sel   = entries[i];
            end
        end
    end

    // A miss leaves sel zeroed, so the page fields read back as 0 without extra gating.
    assign pfn = odd_page ? sel.pfn1 : sel.pfn0;
    assign c   = odd_page ? sel.c1   : sel.c0;
    assign d   = odd_page ? sel.d1   : sel.d0;
    assign v   = odd_page ? sel.v1   : sel.v0;

endmodule

// File: rtl/tlb.sv
// Joint TLB: flop-based entry array with one write port, one read port, two
// combinational search ports, and the CP0 Random counter for TLBWR.
module tlb
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDX_W  = $clog2(TLBNUM)
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic [TLB_VPN2_W-1:0] s0_vpn2,
    input  logic                  s0_odd_page,
    input  logic [TLB_ASID_W-1:0] s0_asid,
    output logic                  s0_found,
    output logic [IDX_W-1:0]      s0_index,
    output logic [TLB_PFN_W-1:0]  s0_pfn,
    output logic [TLB_C_W-1:0]    s0_c,
    output logic                  s0_d,
    output logic                  s0_v,

    input  logic [TLB_VPN2_W-1:0] s1_vpn2,
    input  logic                  s1_odd_page,
    input  logic [TLB_ASID_W-1:0] s1_asid,
    output logic                  s1_found,
    output logic [IDX_W-1:0]      s1_index,
    output logic [TLB_PFN_W-1:0]  s1_pfn,
    output logic [TLB_C_W-1:0]    s1_c,
    output logic                  s1_d,
    output logic                  s1_v,

    input  logic                  we,
    input  logic [IDX_W-1:0]      w_index,
    input  logic [TLB_VPN2_W-1:0] w_vpn2,
    input  logic [TLB_ASID_W-1:0] w_asid,
    input  logic                  w_g,
    input  logic [TLB_PFN_W-1:0]  w_pfn0,
    input  logic [TLB_C_W-1:0]    w_c0,
    input  logic                  w_d0,
    input  logic                  w_v0,
    input  logic [TLB_PFN_W-1:0]  w_pfn1,
    input  logic [TLB_C_W-1:0]    w_c1,
    input  logic                  w_d1,
    input  logic                  w_v1,

    input  logic [IDX_W-1:0]      r_index,
    output logic [TLB_VPN2_W-1:0] r_vpn2,
    output logic [TLB_ASID_W-1:0] r_asid,
    output logic                  r_g,
    output logic [TLB_PFN_W-1:0]  r_pfn0,
    output logic [TLB_C_W-1:0]    r_c0,
    output logic                  r_d0,
    output logic                  r_v0,
    output logic [TLB_PFN_W-1:0]  r_pfn1,
    output logic [TLB_C_W-1:0]    r_c1,
    output logic                  r_d1,
    output logic                  r_v1,

    input  logic [IDX_W-1:0]      wired,
    output logic [IDX_W-1:0]      random
);

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLBNUM - 1);

    tlb_entry_t       entries_q [TLBNUM];
    tlb_entry_t       w_entry;
    tlb_entry_t       r_entry;
    logic [IDX_W-1:0] random_q, random_d;
    logic [IDX_W-1:0] wired_q;
    logic             wired_vld_q;
    logic             wired_chg;

    assign w_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                       pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                       pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

    // NOTE: the entry array is reset on purpose: zeroed entries (g=0, v=0) are
    // architecturally visible to search and TLBR straight out of reset.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values and same-cycle searches see the old entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                entries_q[i] <= '0;
            end
        end else if (we) begin
            entries_q[w_index] <= w_entry;
        end
    end

    assign r_entry = entries_q[r_index];
    assign r_vpn2  = r_entry.vpn2;
    assign r_asid  = r_entry.asid;
    assign r_g     = r_entry.g;
    assign r_pfn0  = r_entry.pfn0;
    assign r_c0    = r_entry.c0;
    assign r_d0    = r_entry.d0;
    assign r_v0    = r_entry.v0;
    assign r_pfn1  = r_entry.pfn1;
    assign r_c1    = r_entry.c1;
    assign r_d1    = r_entry.d1;
    assign r_v1    = r_entry.v1;

    tlb_match #(.TLBNUM(TLBNUM)) u_match_s0 (
        .entries  (entries_q),
        .vpn2     (s0_vpn2),
        .odd_page (s0_odd_page),
        .asid     (s0_asid),
        .found    (s0_found),
        .index    (s0_index),
        .pfn      (s0_pfn),
        .c        (s0_c),
        .d        (s0_d),
        .v        (s0_v)
    );

    tlb_match #(.TLBNUM(TLBNUM)) u_match_s1 (
        .entries  (entries_q),
        .vpn2     (s1_vpn2),
        .odd_page (s1_odd_page),
        .asid     (s1_asid),
        .found    (s1_found),
        .index    (s1_index),
        .pfn      (s1_pfn),
        .c        (s1_c),
        .d        (s1_d),
        .v        (s1_v)
    );

    // The first cycle after reset has no previous Wired to compare against, so
    // wired_vld_q suppresses a spurious reload there.
    assign wired_chg = wired_vld_q && (wired != wired_q);

    always_comb begin
        random_d = random_q - IDX_W'(1);
        if (wired >= RAND_TOP || random_q <= wired || wired_chg) begin
            random_d = RAND_TOP;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random_q    <= RAND_TOP;
            wired_q     <= '0;
            wired_vld_q <= 1'b0;
        end else begin
            random_q    <= random_d;
            wired_q     <= wired;
            wired_vld_q <= 1'b1;
        end
    end

    assign random = random_q;

endmodule
